// File: rtl/spike_rate_encoder_pkg.sv
// Shared definitions for the spike rate encoder: FSM states, LFSR polynomial and seed,
// and a rotate helper used to derive per-channel random bytes from one LFSR word.
// Pure declarations, no logic.
package spike_rate_encoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int          LFSR_W            = 16;
   // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Rotate a 16-bit word left by sh positions (sh = 0 returns q unchanged)
   function automatic logic [15:0] rotl16(input logic [15:0] q, input logic [3:0] sh);
      return (q << sh) | (q >> (5'd16 - {1'b0, sh}));
   endfunction

endpackage

// File: rtl/spike_rate_encoder_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and advance enable.
// Latency: q updates on the clock edge after load/advance; load wins over advance.
// No backpressure: advances exactly once per cycle with advance=1.
module lfsr16
   import spike_rate_encoder_pkg::*;
#(
   parameter logic [15:0] RST_SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic [15:0] q
);

   // Seed on reset or load, otherwise shift right and fold the taps in when bit 0 falls out
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RST_SEED;
      end else if (load) begin
         q <= seed;
      end else if (advance) begin
         q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/spike_rate_encoder.sv
// Converts N_CH latched intensities into spike trains, one timestep per step_en in RUN.
// Latency: spike_out/spike_valid appear 1 cycle after the accepted step_en.
// Backpressure: step_en=0 stalls the run; start is ignored while busy.
module spike_rate_encoder
   import spike_rate_encoder_pkg::*;
#(
   parameter int          N_CH      = 8,
   parameter int          DW        = 8,
   parameter int          STEPW     = 8,
   parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic [N_CH*DW-1:0] intensity,
   input  logic [STEPW-1:0]   num_steps,
   input  logic               step_en,
   output logic [N_CH-1:0]    spike_out,
   output logic               spike_valid,
   output logic               busy,
   output logic               done,
   output logic [STEPW-1:0]   step_count
);

   localparam logic [15:0] RND_MASK = 16'((32'd1 << DW) - 1);

   state_t              state_q, state_d;
   logic                accept_start;
   logic                do_step;
   logic                mode_q;
   logic [N_CH*DW-1:0]  int_q;
   logic [STEPW-1:0]    num_steps_q;
   logic [DW-1:0]       acc_q [N_CH];
   logic [DW-1:0]       acc_d [N_CH];
   logic [N_CH-1:0]     det_spk;
   logic [N_CH-1:0]     sto_spk;
   logic [15:0]         lfsr_q;

   lfsr16 #(.RST_SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (accept_start),
      .seed    (LFSR_SEED),
      .advance (do_step & mode_q),
      .q       (lfsr_q)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle control strobes
   always_comb begin
      state_d      = state_q;
      accept_start = 1'b0;
      do_step      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept_start = 1'b1;
               state_d      = (num_steps == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (step_en) begin
               do_step = 1'b1;
               if (step_count + STEPW'(1) == num_steps_q) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

   // Candidate spikes for both encodings from the current accumulators and pre-advance LFSR
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         logic [DW:0]   sum;
         logic [15:0]   rot;
         sum        = {1'b0, acc_q[i]} + {1'b0, int_q[i*DW +: DW]};
         acc_d[i]   = sum[DW-1:0];
         det_spk[i] = sum[DW];
         rot        = rotl16(lfsr_q, 4'(i));
         sto_spk[i] = 16'(int_q[i*DW +: DW]) > (rot & RND_MASK);
      end
   end

   // Run parameters, accumulators, step counter and the registered spike vector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spike_out   <= '0;
         spike_valid <= 1'b0;
         step_count  <= '0;
         mode_q      <= 1'b0;
         int_q       <= '0;
         num_steps_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         spike_out   <= '0;
         spike_valid <= 1'b0;
         if (accept_start) begin
            mode_q      <= mode;
            int_q       <= intensity;
            num_steps_q <= num_steps;
            step_count  <= '0;
            for (int i = 0; i < N_CH; i++) begin
               acc_q[i] <= '0;
            end
         end else if (do_step) begin
            spike_valid <= 1'b1;
            spike_out   <= mode_q ? sto_spk : det_spk;
            if (step_count != num_steps_q) begin
               step_count <= step_count + STEPW'(1);
            end
            if (!mode_q) begin
               for (int i = 0; i < N_CH; i++) begin
                  acc_q[i] <= acc_d[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: reset, deterministic rates, stalls,
// zero-length run, stochastic reproducibility/statistics and ignored restart.
module tb_spike_rate_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic [63:0] intensity;
   logic [7:0]  num_steps;
   logic        step_en;
   logic [7:0]  spike_out;
   logic        spike_valid;
   logic        busy;
   logic        done;
   logic [7:0]  step_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp2 [8] = '{8'h00, 8'h03, 8'h02, 8'h0B, 8'h02, 8'h03, 8'h02, 8'h0B};
   logic       pat3 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [7:0] run1 [200];
   logic [7:0] run2 [200];

   spike_rate_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mode        (mode),
      .intensity   (intensity),
      .num_steps   (num_steps),
      .step_en     (step_en),
      .spike_out   (spike_out),
      .spike_valid (spike_valid),
      .busy        (busy),
      .done        (done),
      .step_count  (step_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pack4(input logic [7:0] c0, input logic [7:0] c1,
                                         input logic [7:0] c2, input logic [7:0] c3);
      return {32'h0, c3, c2, c1, c0};
   endfunction

   // Mode-0 run of 8 steps; optionally re-asserts start with new inputs mid-run
   task automatic run_det8(input string pfx, input bit restart);
      mode      = 1'b0;
      intensity = pack4(8'd128, 8'd255, 8'd0, 8'd64);
      num_steps = 8'd8;
      step_en   = 1'b0;
      start     = 1'b1;
      tick;
      start = 1'b0;
      chk({pfx, "_busy_run"}, busy, 1);
      chk({pfx, "_valid_idle"}, spike_valid, 0);
      step_en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         if (restart && s == 3) begin
            start     = 1'b1;
            mode      = 1'b1;
            intensity = {8{8'hFF}};
            num_steps = 8'd3;
         end else begin
            start = 1'b0;
         end
         tick;
         chk($sformatf("%s_valid%0d", pfx, s + 1), spike_valid, 1);
         chk($sformatf("%s_out%0d", pfx, s + 1), spike_out, exp2[s]);
         chk($sformatf("%s_cnt%0d", pfx, s + 1), step_count, s + 1);
         chk($sformatf("%s_done%0d", pfx, s + 1), done, (s == 7) ? 1 : 0);
      end
      start   = 1'b0;
      step_en = 1'b0;
      mode    = 1'b0;
      tick;
      chk({pfx, "_done_clr"}, done, 0);
      chk({pfx, "_busy_clr"}, busy, 0);
      chk({pfx, "_valid_clr"}, spike_valid, 0);
      chk({pfx, "_out_clr"}, spike_out, 0);
      chk({pfx, "_cnt_hold"}, step_count, 8);
   endtask

   initial begin
      int n;
      int pulses;
      int nvalid;
      int diffs;
      int c0, c1, c2;

      // Reset state
      reset     = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      step_en   = 1'b0;
      intensity = '0;
      num_steps = '0;
      tick;
      chk("rst_out", spike_out, 0);
      chk("rst_valid", spike_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", step_count, 0);
      reset = 1'b0;
      tick;

      // Reset in the middle of a 10-step run
      mode      = 1'b0;
      intensity = pack4(8'd128, 8'd255, 8'd0, 8'd64);
      num_steps = 8'd10;
      start     = 1'b1;
      tick;
      start = 1'b0;
      chk("t1_busy", busy, 1);
      step_en = 1'b1;
      tick;
      tick;
      tick;
      chk("t1_cnt3", step_count, 3);
      chk("t1_out3", spike_out, 8'h02);
      reset = 1'b1;
      tick;
      chk("t1_rst_out", spike_out, 0);
      chk("t1_rst_valid", spike_valid, 0);
      chk("t1_rst_busy", busy, 0);
      chk("t1_rst_done", done, 0);
      chk("t1_rst_cnt", step_count, 0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("t1_nodone%0d", k), done, 0);
         chk($sformatf("t1_idle%0d", k), busy, 0);
      end
      step_en = 1'b0;
      tick;

      // Deterministic 8-step run with constant step_en
      run_det8("t2", 1'b0);

      // Stalled run: step_en 1,0,0,1,1,0,1 over 4 steps
      mode      = 1'b0;
      intensity = pack4(8'd128, 8'd0, 8'd0, 8'd0);
      num_steps = 8'd4;
      start     = 1'b1;
      tick;
      start  = 1'b0;
      n      = 0;
      pulses = 0;
      for (int k = 0; k < 7; k++) begin
         step_en = pat3[k];
         tick;
         if (pat3[k]) n++;
         if (spike_valid) pulses++;
         chk($sformatf("t3_valid%0d", k), spike_valid, pat3[k]);
         chk($sformatf("t3_cnt%0d", k), step_count, n);
         chk($sformatf("t3_out%0d", k), spike_out, (pat3[k] && (n % 2 == 0)) ? 1 : 0);
         chk($sformatf("t3_done%0d", k), done, (pat3[k] && n == 4) ? 1 : 0);
      end
      chk("t3_pulses", pulses, 4);
      step_en = 1'b0;
      tick;
      chk("t3_idle", busy, 0);

      // Zero-length run
      num_steps = 8'd0;
      step_en   = 1'b1;
      start     = 1'b1;
      tick;
      start = 1'b0;
      chk("t4_busy", busy, 1);
      chk("t4_done", done, 1);
      chk("t4_valid", spike_valid, 0);
      tick;
      chk("t4_busy_clr", busy, 0);
      chk("t4_done_clr", done, 0);
      chk("t4_valid2", spike_valid, 0);
      chk("t4_cnt", step_count, 0);
      step_en = 1'b0;
      tick;

      // Stochastic runs, twice with identical inputs
      for (int pass = 0; pass < 2; pass++) begin
         mode      = 1'b1;
         intensity = pack4(8'd0, 8'd255, 8'd128, 8'd200);
         num_steps = 8'd200;
         start     = 1'b1;
         tick;
         start   = 1'b0;
         step_en = 1'b1;
         nvalid  = 0;
         for (int s = 0; s < 200; s++) begin
            tick;
            if (spike_valid) nvalid++;
            if (pass == 0) run1[s] = spike_out;
            else           run2[s] = spike_out;
         end
         chk($sformatf("t5_valid_p%0d", pass), nvalid, 200);
         chk($sformatf("t5_done_p%0d", pass), done, 1);
         chk($sformatf("t5_cnt_p%0d", pass), step_count, 200);
         step_en = 1'b0;
         tick;
      end
      chk("t5_step1", run1[0], 8'h0A);
      chk("t5_step2", run1[1], 8'h0A);
      diffs = 0;
      c0 = 0;
      c1 = 0;
      c2 = 0;
      for (int s = 0; s < 200; s++) begin
         if (run1[s] !== run2[s]) diffs++;
         c0 += int'(run1[s][0]);
         c1 += int'(run1[s][1]);
         c2 += int'(run1[s][2]);
      end
      chk("t5_repeat_diffs", diffs, 0);
      chk("t5_ch_zero", c0, 0);
      chk("t5_ch255_ge198", (c1 >= 198) ? 1 : 0, 1);
      chk("t5_ch128_range", (c2 >= 80 && c2 <= 120) ? 1 : 0, 1);

      // Restart during RUN must not re-latch
      run_det8("t6", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
